fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage between the PC unit and the decode stage. It issues one instruction-memory request per PC value, waits for a variable-latency response, and captures the instruction with its PC+4 into the IF/ID pipeline register. It returns `FetchStall` to the PC unit's stall input so the PC advances only when an instruction is actually handed to decode. It also squashes in-flight or buffered fetches on a control-flow redirect.

## Interface
- `RESET_PC`, 32'h80000000: PC value after reset; `IF_ID_PCplus4` resets to this value.
- `NOP`, 32'h00000000: instruction word driven into IF/ID on a bubble.

- `CLK`  in  1  single clock; all state changes on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `PC`  in  32  current PC from the PC unit.
- `PCplus4`  in  32  PC+4 from the PC unit, bit 31 already preserved.
- `ID_Stall`  in  1  decode cannot accept a new instruction this cycle.
- `Flush`  in  1  PC is being redirected at this edge (taken branch or jump).
- `IMemReq`  out  1  request strobe, one-cycle pulse.
- `IMemAddr`  out  32  request address, equal to `PC`.
- `IMemValid`  in  1  response valid, at least 1 cycle after the request.
- `IMemData`  in  32  response instruction word.
- `FetchStall`  out  1  hold the PC; ORed into the PC unit's stall input.
- `IF_ID_Instruction`  out  32  registered instruction for decode.
- `IF_ID_PCplus4`  out  32  registered PC+4 of that instruction.
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction, not a bubble.

## Operation
- **States:** REQ, WAIT, HOLD. A separate `Squash` flag records that the outstanding response must be dropped.
- **REQ**
  - `IMemReq`=1 and `IMemAddr`=`PC`.
  - Next state is always WAIT.
  - On Flush in REQ, `Squash` is set, because the request just issued targets the killed path.
- **WAIT**
  - `IMemReq`=0.
  - On `IMemValid` with `Squash`=1: drop the data, clear `Squash`, go to REQ. `FetchStall` stays 1.
  - On `IMemValid` with `Squash`=0 and `ID_Stall`=0: load IF/ID with {`IMemData`, `PCplus4`, Valid=1}, drive `FetchStall`=0 for that cycle, go to REQ.
  - On `IMemValid` with `Squash`=0 and `ID_Stall`=1: latch {`IMemData`, `PCplus4`} into the hold buffer and go to HOLD. IF/ID is unchanged.
  - On Flush in WAIT, `Squash` is set and any response arriving in the same cycle is dropped.
- **HOLD**
  - When `ID_Stall` drops, load IF/ID from the buffer, drive `FetchStall`=0, and go to REQ.
  - On Flush, discard the buffer and go to REQ.
- **FetchStall** is 1 in every cycle except a delivery cycle.
- **IF/ID register**
  - If `ID_Stall`=1 and `Flush`=0, hold.
  - If `Flush`=1, load a bubble (`NOP`, Valid=0). Flush beats `ID_Stall`.
  - If no delivery and no stall, load a bubble.
- **Flush precedence:** Flush overrides delivery in the same cycle. The delivered data is not written and the state goes to REQ. The PC has already been redirected, so the next request uses the new PC.
- **Widths:** all datapath widths are 32 bits with no arithmetic; PC+4 is taken from the PC unit.

## Timing
- **Reset values:**
  - state=REQ, `Squash`=0, buffer=0.
  - `IMemReq`=0 while `Reset_n`=0; `IMemReq` rises combinationally in the first cycle after release.
  - `IF_ID_Instruction`=`NOP`, `IF_ID_PCplus4`=`RESET_PC`, `IF_ID_Valid`=0, `FetchStall`=1.
- **Reset mid-operation:** asynchronous return to the reset values. A memory response that arrives after release while in REQ is ignored.
- **Latency and throughput:**
  - With memory latency L≥1, the instruction appears in IF/ID L+1 edges after the REQ cycle.
  - Sustained throughput is one instruction per L+1 cycles.
- **Outputs:** `IMemReq`, `IMemAddr` and `FetchStall` are combinational from state and inputs. IF/ID outputs are registered.
- **Input validity:** `IMemValid` asserted in REQ is a protocol violation and is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t`, a 2-bit enum: REQ=0, WAIT=1, HOLD=2.
  - `NOP_INSTR`.
  - `RESET_PC` (32'h80000000), shared with the PC unit.
- Natural sub-module `if_id_reg`: the IF/ID register with load, hold and bubble controls. The FSM, `Squash` flag and hold buffer stay in `fetch_stage`.

## Test plan
- **Reset release, L=1:**
  - `IMemReq`=1 with `IMemAddr`=0x80000000 in cycle 0.
  - `IMemValid` in cycle 1 with 0x20080005 produces IF/ID {0x20080005, 0x80000004, 1} after edge 2.
  - `FetchStall` is 0 only in cycle 1.
- **Stall at delivery, L=3:**
  - `ID_Stall`=1 when data 0xAABBCCDD arrives, held for 2 cycles: state goes to HOLD and `FetchStall` stays 1.
  - When `ID_Stall` drops, IF/ID loads 0xAABBCCDD and `FetchStall`=0 for exactly 1 cycle.
- **Flush in WAIT:**
  - Flush one cycle before `IMemValid`: the returning word is discarded and `IF_ID_Valid`=0.
  - Next REQ carries the new PC, 0x80000040.
- **Flush in same cycle as delivery:** IF/ID gets a bubble, state goes to REQ, and no stale instruction reaches decode.
- **Flush plus `ID_Stall` in HOLD:** buffer discarded, IF/ID becomes `NOP`/Valid=0, state goes to REQ.
- **Reset asserted in WAIT with `Squash`=1:** all outputs return to reset values immediately; a late `IMemValid` after release is ignored.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the fetch stage, its IF/ID register and the
// PC unit.
//   RESET_PC      : PC value after reset
//   NOP_INSTR     : instruction word used for pipeline bubbles
//   fetch_state_t : fetch FSM state encoding
//   fetch_entry_t : instruction word paired with its PC+4
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [31:0] RESET_PC  = 32'h8000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/response channel.
//   IMemReq   : one-cycle request strobe
//   IMemAddr  : request address
//   IMemValid : response valid, at least one cycle after the request
//   IMemData  : response instruction word
// master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if;

   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemValid;
   logic [31:0] IMemData;

   modport master (
      output IMemReq,
      output IMemAddr,
      input  IMemValid,
      input  IMemData
   );

   modport slave (
      input  IMemReq,
      input  IMemAddr,
      output IMemValid,
      output IMemData
   );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.  Priority: flush -> bubble, load -> new entry,
// stall -> hold, otherwise bubble.
//   CLK, Reset_n : clock, asynchronous active-low reset
//   load         : capture din as a valid instruction
//   stall        : decode cannot accept; keep current contents
//   flush        : force a bubble regardless of stall
//   din          : instruction and PC+4 to capture
//   instr, pc4   : registered instruction and its PC+4
//   valid        : register holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg
   import cpu_pkg::*;
(
   input  logic         CLK,
   input  logic         Reset_n,
   input  logic         load,
   input  logic         stall,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [31:0]  instr,
   output logic [31:0]  pc4,
   output logic         valid
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         instr <= NOP_INSTR;
         pc4   <= RESET_PC;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (load) begin
         instr <= din.instr;
         pc4   <= din.pc4;
         valid <= 1'b1;
      end else if (!stall) begin
         // Bubbles keep the last PC+4; only the instruction and valid change.
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Issues one instruction-memory request per PC, waits for the variable-latency
// response and hands the instruction plus PC+4 to decode through IF/ID.
//   CLK, Reset_n      : clock, asynchronous active-low reset
//   PC, PCplus4       : current PC and PC+4 from the PC unit
//   ID_Stall          : decode cannot accept a new instruction
//   Flush             : PC is redirected at this edge
//   imem              : instruction-memory channel (master side)
//   FetchStall        : hold the PC; low only in a delivery cycle
//   IF_ID_Instruction : registered instruction for decode
//   IF_ID_PCplus4     : registered PC+4 of that instruction
//   IF_ID_Valid       : IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage
   import cpu_pkg::*;
(
   input  logic          CLK,
   input  logic          Reset_n,
   input  logic [31:0]   PC,
   input  logic [31:0]   PCplus4,
   input  logic          ID_Stall,
   input  logic          Flush,
   fetch_stage_if.master imem,
   output logic          FetchStall,
   output logic [31:0]   IF_ID_Instruction,
   output logic [31:0]   IF_ID_PCplus4,
   output logic          IF_ID_Valid
);

   fetch_state_t state;
   logic         squash;    // outstanding response belongs to a killed path
   fetch_entry_t hold_buf;  // response captured while decode was stalled

   logic         resp_live;
   logic         deliver;
   fetch_entry_t deliver_data;

   // A response is usable only if it is not squashed and no redirect is
   // happening in the same cycle; Flush always wins over delivery.
   assign resp_live = (state == WAIT) && imem.IMemValid && !squash && !Flush;

   assign deliver = (resp_live && !ID_Stall) ||
                    ((state == HOLD) && !ID_Stall && !Flush);

   assign deliver_data = (state == HOLD) ? hold_buf
                                         : fetch_entry_t'{instr: imem.IMemData, pc4: PCplus4};

   // Gated by reset so no request escapes while the FSM sits in its REQ reset
   // state; it rises as soon as reset is released.
   assign imem.IMemReq  = Reset_n && (state == REQ);
   assign imem.IMemAddr = PC;
   assign FetchStall    = !deliver;

   // NOTE: the hold buffer is reset along with the control state so the
   // register bank comes up in a known value after every reset.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= REQ;
         squash   <= 1'b0;
         hold_buf <= '0;
      end else begin
         unique case (state)
            REQ: begin
               state  <= WAIT;
               // The request issued this cycle targets the path being killed.
               squash <= Flush;
            end
            WAIT: begin
               if (imem.IMemValid) begin
                  squash <= 1'b0;
                  if (squash || Flush || !ID_Stall) begin
                     state <= REQ;
                  end else begin
                     hold_buf <= fetch_entry_t'{instr: imem.IMemData, pc4: PCplus4};
                     state    <= HOLD;
                  end
               end else if (Flush) begin
                  squash <= 1'b1;
               end
            end
            HOLD: begin
               // A flush simply abandons the buffer; its contents are never read
               // again until refilled.
               if (Flush || !ID_Stall) state <= REQ;
            end
            default: state <= REQ;
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .load    (deliver),
      .stall   (ID_Stall),
      .flush   (Flush),
      .din     (deliver_data),
      .instr   (IF_ID_Instruction),
      .pc4     (IF_ID_PCplus4),
      .valid   (IF_ID_Valid)
   );

endmodule
